// File: rtl/arith_seq_divider.sv
// Multi-cycle restoring divider: unsigned A / B over WIDTH enabled cycles,
// start/busy/done handshake with an active-low enable that freezes the block.
module arith_seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable_low,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic [2*WIDTH-1:0] y,
   output logic               div_by_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH-1:0] r_sub;
   logic [WIDTH-1:0] a_shift;
   logic             ge;

   // The shifted remainder needs WIDTH+1 bits, but after each restoring step it
   // is below B, so only WIDTH bits are stored and the subtraction wraps safely.
   always_comb begin
      r_shift = {r_q, a_q[WIDTH-1]};
      a_shift = a_q << 1;
      ge      = (r_shift >= {1'b0, b_q});
      r_sub   = r_shift[WIDTH-1:0] - b_q;
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      if (!enable_low) begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_d   = A;
                  b_d   = B;
                  r_d   = '0;
                  cnt_d = '0;
                  dbz_d = 1'b0;
                  if (B == '0) begin
                     quotient_d  = '1;
                     remainder_d = A;
                     dbz_d       = 1'b1;
                     state_d     = S_DONE;
                  end else begin
                     state_d = S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (ge) begin
                  r_d = r_sub;
                  a_d = a_shift | WIDTH'(1);
               end else begin
                  r_d = r_shift[WIDTH-1:0];
                  a_d = a_shift;
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  quotient_d  = a_d;
                  remainder_d = r_d;
                  state_d     = S_DONE;
               end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   always_comb begin
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_DONE);
      quotient    = quotient_q;
      remainder   = remainder_q;
      y           = {remainder_q, quotient_q};
      div_by_zero = dbz_q;
   end

endmodule
